note_scroller: RTL and testbench

// Hardware note-sprite engine upstream of the VGA frame buffer. It owns write port A of vga_ram
// (vga_ram_addr/din/we), holds up to NUM_SLOTS falling notes, and draws them as NOTE_H-row bars
// in lanes 0..6. Each frame_tick moves every note down SPEED rows. It retires notes with a miss

---
 rtl/note_scroller_if.sv | 35 +++
 rtl/note_scroller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_note_scroller.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_scroller_if.sv
// note_scroller_if: groups the note engine's request/response handshakes and
// the vga_ram port A write strobes.
//   master : drives frame_tick, spawn/hit requests; observes everything else
//   slave  : the note engine itself
interface note_scroller_if;
   logic        frame_tick;
   logic        spawn_valid;
   logic [2:0]  spawn_lane;
   logic        spawn_ready;
   logic        spawn_drop;
   logic        hit_valid;
   logic [2:0]  hit_lane;
   logic        hit_ready;
   logic        hit_ok;
   logic        hit_fail;
   logic        miss;
   logic [2:0]  miss_lane;
   logic        tick_overrun;
   logic        busy;
   logic [11:0] vga_ram_addr;
   logic        vga_ram_din;
   logic        vga_ram_we;

   modport master (
      output frame_tick, spawn_valid, spawn_lane, hit_valid, hit_lane,
      input  spawn_ready, spawn_drop, hit_ready, hit_ok, hit_fail, miss, miss_lane,
             tick_overrun, busy, vga_ram_addr, vga_ram_din, vga_ram_we
   );

   modport slave (
      input  frame_tick, spawn_valid, spawn_lane, hit_valid, hit_lane,
      output spawn_ready, spawn_drop, hit_ready, hit_ok, hit_fail, miss, miss_lane,
             tick_overrun, busy, vga_ram_addr, vga_ram_din, vga_ram_we
   );
endinterface

// File: rtl/note_scroller.sv
// note_scroller: falling-note sprite engine owning vga_ram write port A.
// Holds NUM_SLOTS notes, redraws them every frame_tick, retires notes at the
// bottom (miss) and resolves hit requests against a row window.
// Ports:
//   clk50 - system clock, also vga_ram port A clock
//   rst_n - asynchronous reset, active low
//   bus   - note_scroller_if.slave: frame_tick, spawn/hit handshakes, result
//           pulses, busy, vga_ram_addr/din/we ({row[8:0], lane[2:0]})
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | write background to all 4096 addresses
// ST_IDLE  | accept tick (highest), hit, then spawn
// ST_DRAW  | write NOTE_H note pixels of slot cur, rows ascending
// ST_TICK  | visit slot idx; inactive slots cost one cycle
// ST_ERASE | write NOTE_H background pixels of slot cur
// ST_HSCAN | scan slot idx for the best hit candidate
module note_scroller #(
   parameter int NUM_SLOTS = 8,
   parameter int NOTE_H    = 16,
   parameter int SPEED     = 2,
   parameter int MAX_TOP   = 464,
   parameter int HIT_TOP   = 400,
   parameter int HIT_BOT   = 448
) (
   input logic            clk50,
   input logic            rst_n,
   note_scroller_if.slave bus
);
   localparam int IW = $clog2(NUM_SLOTS);
   localparam int HW = $clog2(NOTE_H);
   localparam logic [9:0] MAX_TOP_P = 10'(MAX_TOP);
   localparam logic [8:0] HIT_TOP_P = 9'(HIT_TOP);
   localparam logic [8:0] HIT_BOT_P = 9'(HIT_BOT);

   typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_DRAW, ST_TICK, ST_ERASE, ST_HSCAN} state_t;
   state_t state, state_n;

   logic          slot_act  [NUM_SLOTS];
   logic [2:0]    slot_lane [NUM_SLOTS];
   logic [8:0]    slot_pos  [NUM_SLOTS];

   logic [11:0]   clr_cnt;
   logic [IW-1:0] idx, cur, best_idx, free_idx;
   logic [HW-1:0] wcnt;
   logic [8:0]    best_pos, cur_row;
   logic [9:0]    new_pos;
   logic [2:0]    h_lane;
   logic          op_tick, tick_pend, best_found, free_found, last_idx, rdy;
   logic          cand, take;

   logic          we_n, din_n;
   logic [11:0]   addr_n;
   logic          spawn_acc, hit_acc, tick_go, drop_n, ok_n, fail_n, miss_n;
   logic          idx_inc, wcnt_ld, cur_from_idx, cur_from_best, free_cur, move_cur;

   // Lowest inactive slot wins: iterate downward so the last hit is the lowest.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_act[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   // wcnt counts down, so the row offset within the note is (NOTE_H-1) - wcnt.
   assign cur_row  = slot_pos[cur] + 9'(NOTE_H - 1) - 9'(wcnt);
   assign new_pos  = {1'b0, slot_pos[cur]} + 10'(SPEED);
   assign last_idx = (idx == IW'(NUM_SLOTS - 1));
   assign cand     = slot_act[idx] && (slot_lane[idx] == h_lane) &&
                     (slot_pos[idx] >= HIT_TOP_P) && (slot_pos[idx] <= HIT_BOT_P);
   // Strict compare keeps the earlier (lower-index) slot on equal positions.
   assign take     = cand && (!best_found || (slot_pos[idx] > best_pos));

   assign rdy             = (state == ST_IDLE) && !tick_pend;
   assign bus.hit_ready   = rdy;
   assign bus.spawn_ready = rdy && !bus.hit_valid;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) state <= ST_CLEAR;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      we_n          = 1'b0;
      din_n         = 1'b0;
      addr_n        = '0;
      spawn_acc     = 1'b0;
      hit_acc       = 1'b0;
      tick_go       = 1'b0;
      drop_n        = 1'b0;
      ok_n          = 1'b0;
      fail_n        = 1'b0;
      miss_n        = 1'b0;
      idx_inc       = 1'b0;
      wcnt_ld       = 1'b0;
      cur_from_idx  = 1'b0;
      cur_from_best = 1'b0;
      free_cur      = 1'b0;
      move_cur      = 1'b0;
      case (state)
         ST_CLEAR: begin
            we_n   = 1'b1;
            addr_n = clr_cnt;
            if (clr_cnt == 12'hfff) state_n = ST_IDLE;
         end
         ST_IDLE: begin
            if (tick_pend) begin
               tick_go = 1'b1;
               state_n = ST_TICK;
            end else if (bus.hit_valid) begin
               hit_acc = 1'b1;
               state_n = ST_HSCAN;
            end else if (bus.spawn_valid) begin
               if (free_found && (bus.spawn_lane != 3'd7)) begin
                  spawn_acc = 1'b1;
                  wcnt_ld   = 1'b1;
                  state_n   = ST_DRAW;
               end else begin
                  drop_n = 1'b1;
               end
            end
         end
         ST_DRAW: begin
            we_n   = 1'b1;
            din_n  = 1'b1;
            addr_n = {cur_row, slot_lane[cur]};
            if (wcnt == '0) begin
               if (op_tick && !last_idx) begin
                  idx_inc = 1'b1;
                  state_n = ST_TICK;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_TICK: begin
            if (slot_act[idx]) begin
               cur_from_idx = 1'b1;
               wcnt_ld      = 1'b1;
               state_n      = ST_ERASE;
            end else if (last_idx) begin
               state_n = ST_IDLE;
            end else begin
               idx_inc = 1'b1;
            end
         end
         ST_ERASE: begin
            we_n   = 1'b1;
            addr_n = {cur_row, slot_lane[cur]};
            if (wcnt == '0) begin
               if (!op_tick) begin
                  free_cur = 1'b1;
                  state_n  = ST_IDLE;
               end else if (new_pos > MAX_TOP_P) begin
                  free_cur = 1'b1;
                  miss_n   = 1'b1;
                  if (last_idx) begin
                     state_n = ST_IDLE;
                  end else begin
                     idx_inc = 1'b1;
                     state_n = ST_TICK;
                  end
               end else begin
                  move_cur = 1'b1;
                  wcnt_ld  = 1'b1;
                  state_n  = ST_DRAW;
               end
            end
         end
         ST_HSCAN: begin
            if (last_idx) begin
               if (take || best_found) begin
                  ok_n          = 1'b1;
                  cur_from_best = 1'b1;
                  wcnt_ld       = 1'b1;
                  state_n       = ST_ERASE;
               end else begin
                  fail_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end else begin
               idx_inc = 1'b1;
            end
         end
         default: state_n = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_act[i]  <= 1'b0;
            slot_lane[i] <= '0;
            slot_pos[i]  <= '0;
         end
         clr_cnt          <= '0;
         idx              <= '0;
         cur              <= '0;
         best_idx         <= '0;
         best_pos         <= '0;
         best_found       <= 1'b0;
         wcnt             <= '0;
         h_lane           <= '0;
         op_tick          <= 1'b0;
         tick_pend        <= 1'b0;
         bus.tick_overrun <= 1'b0;
         bus.spawn_drop   <= 1'b0;
         bus.hit_ok       <= 1'b0;
         bus.hit_fail     <= 1'b0;
         bus.miss         <= 1'b0;
         bus.miss_lane    <= '0;
         bus.busy         <= 1'b0;
         bus.vga_ram_we   <= 1'b0;
         bus.vga_ram_din  <= 1'b0;
         bus.vga_ram_addr <= '0;
      end else begin
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + 12'd1;
         // A new tick landing in the same cycle it is consumed becomes the next pending one.
         if (bus.frame_tick)  tick_pend <= 1'b1;
         else if (tick_go)    tick_pend <= 1'b0;
         bus.tick_overrun <= bus.frame_tick && tick_pend && !tick_go;

         if (tick_go) begin
            op_tick <= 1'b1;
            idx     <= '0;
         end
         if (hit_acc) begin
            op_tick    <= 1'b0;
            idx        <= '0;
            h_lane     <= bus.hit_lane;
            best_found <= 1'b0;
         end
         if (spawn_acc) begin
            op_tick             <= 1'b0;
            cur                 <= free_idx;
            slot_act[free_idx]  <= 1'b1;
            slot_lane[free_idx] <= bus.spawn_lane;
            slot_pos[free_idx]  <= '0;
         end
         if (idx_inc) idx <= idx + IW'(1);
         if ((state == ST_HSCAN) && take) begin
            best_found <= 1'b1;
            best_idx   <= idx;
            best_pos   <= slot_pos[idx];
         end
         if (wcnt_ld)            wcnt <= HW'(NOTE_H - 1);
         else if (wcnt != '0)    wcnt <= wcnt - HW'(1);
         if (cur_from_idx)  cur <= idx;
         if (cur_from_best) cur <= take ? idx : best_idx;
         if (free_cur)      slot_act[cur] <= 1'b0;
         if (move_cur)      slot_pos[cur] <= new_pos[8:0];

         bus.spawn_drop   <= drop_n;
         bus.hit_ok       <= ok_n;
         bus.hit_fail     <= fail_n;
         bus.miss         <= miss_n;
         bus.miss_lane    <= miss_n ? slot_lane[cur] : 3'd0;
         bus.busy         <= (state_n != ST_IDLE);
         bus.vga_ram_we   <= we_n;
         bus.vga_ram_din  <= din_n;
         bus.vga_ram_addr <= addr_n;
      end
   end
endmodule

// File: tb/tb_note_scroller.sv
`timescale 1ns/1ps
module tb_note_scroller;
   localparam int NUM_SLOTS = 8;
   localparam int NOTE_H    = 16;
   localparam int SPEED     = 2;
   localparam int MAX_TOP   = 464;
   localparam int HIT_TOP   = 400;
   localparam int HIT_BOT   = 448;

   logic clk50 = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk50 = ~clk50;

   note_scroller_if bus();

   note_scroller #(
      .NUM_SLOTS(NUM_SLOTS), .NOTE_H(NOTE_H), .SPEED(SPEED),
      .MAX_TOP(MAX_TOP), .HIT_TOP(HIT_TOP), .HIT_BOT(HIT_BOT)
   ) dut (
      .clk50(clk50),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Monitor: everything observed on the write port and result pulses.
   logic [12:0] act_q[$];
   int          act_miss_q[$];
   int          drop_cnt = 0, ok_cnt = 0, fail_cnt = 0, ovr_cnt = 0;

   always @(negedge clk50) begin
      if (bus.vga_ram_we !== 1'b0) act_q.push_back({bus.vga_ram_addr, bus.vga_ram_din});
      if (bus.spawn_drop   === 1'b1) drop_cnt++;
      if (bus.hit_ok       === 1'b1) ok_cnt++;
      if (bus.hit_fail     === 1'b1) fail_cnt++;
      if (bus.tick_overrun === 1'b1) ovr_cnt++;
      if (bus.miss         === 1'b1) act_miss_q.push_back(int'(bus.miss_lane));
   end

   // Reference model: notes as plain integers, expected writes as a stream.
   int          m_act[NUM_SLOTS];
   int          m_lane[NUM_SLOTS];
   int          m_pos[NUM_SLOTS];
   logic [12:0] exp_q[$];
   int          exp_miss_q[$];
   int          exp_drop = 0, exp_ok = 0, exp_fail = 0, exp_ovr = 0;
   int          rd_ptr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic m_note(input int s, input bit din);
      for (int r = 0; r < NOTE_H; r++)
         exp_q.push_back({9'(m_pos[s] + r), 3'(m_lane[s]), din});
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NUM_SLOTS; i++) n += m_act[i];
      return n;
   endfunction

   task automatic m_spawn(input int lane);
      int f = -1;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) if (m_act[i] == 0) f = i;
      if (f < 0 || lane == 7) exp_drop++;
      else begin
         m_act[f] = 1; m_lane[f] = lane; m_pos[f] = 0;
         m_note(f, 1'b1);
      end
   endtask

   task automatic m_tick();
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (m_act[i] != 0) begin
            m_note(i, 1'b0);
            if (m_pos[i] + SPEED > MAX_TOP) begin
               m_act[i] = 0;
               exp_miss_q.push_back(m_lane[i]);
            end else begin
               m_pos[i] += SPEED;
               m_note(i, 1'b1);
            end
         end
      end
   endtask

   task automatic m_hit(input int lane);
      int best = -1;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (m_act[i] != 0 && m_lane[i] == lane && m_pos[i] >= HIT_TOP && m_pos[i] <= HIT_BOT)
            if (best < 0 || m_pos[i] > m_pos[best]) best = i;
      if (best >= 0) begin
         m_note(best, 1'b0);
         m_act[best] = 0;
         exp_ok++;
      end else exp_fail++;
   endtask

   // Idle means busy low for several consecutive cycles (back-to-back ticks dip for one).
   task automatic wait_idle(input string tag, input int budget);
      int n = 0, quiet = 0;
      repeat (3) @(negedge clk50);
      while (quiet < 4 && n < budget) begin
         @(negedge clk50);
         n++;
         quiet = (bus.busy === 1'b0) ? quiet + 1 : 0;
      end
      check({tag, " idle"}, bus.busy, 0);
      repeat (2) @(negedge clk50);
   endtask

   task automatic check_writes(input string tag);
      int n_act = act_q.size() - rd_ptr;
      int mism = 0;
      check({tag, " wr_count"}, n_act, exp_q.size());
      for (int i = 0; i < n_act && i < exp_q.size(); i++)
         if (act_q[rd_ptr + i] !== exp_q[i]) mism++;
      check({tag, " wr_data"}, mism, 0);
      rd_ptr = act_q.size();
      exp_q.delete();
   endtask

   task automatic check_pulses(input string tag);
      check({tag, " drops"},   drop_cnt, exp_drop);
      check({tag, " hit_ok"},  ok_cnt,   exp_ok);
      check({tag, " hit_fail"}, fail_cnt, exp_fail);
      check({tag, " misses"},  act_miss_q.size(), exp_miss_q.size());
      check({tag, " overrun"}, ovr_cnt,  exp_ovr);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk50);
      while (bus.spawn_ready !== 1'b1 && n < 3000) begin
         @(negedge clk50);
         n++;
      end
      check({tag, " ready"}, bus.spawn_ready, 1);
   endtask

   task automatic drive_spawn(input int lane);
      wait_ready("spawn");
      bus.spawn_valid = 1'b1;
      bus.spawn_lane  = 3'(lane);
      @(negedge clk50);
      bus.spawn_valid = 1'b0;
      m_spawn(lane);
      wait_idle("spawn", 3000);
      check_writes("spawn");
      check_pulses("spawn");
   endtask

   task automatic drive_hit(input int lane);
      int lat = 0;
      wait_ready("hit");
      bus.hit_valid = 1'b1;
      bus.hit_lane  = 3'(lane);
      while (lat < 40) begin
         @(negedge clk50);
         lat++;
         bus.hit_valid = 1'b0;
         if (bus.hit_ok === 1'b1 || bus.hit_fail === 1'b1) break;
      end
      check("hit latency", lat, NUM_SLOTS + 1);
      m_hit(lane);
      wait_idle("hit", 3000);
      check_writes("hit");
      check_pulses("hit");
   endtask

   task automatic drive_tick();
      @(negedge clk50);
      bus.frame_tick = 1'b1;
      @(negedge clk50);
      bus.frame_tick = 1'b0;
      m_tick();
      wait_idle("tick", 3000);
      check_writes("tick");
      check_pulses("tick");
   endtask

   initial begin
      int n, mism, base;
      bus.frame_tick  = 1'b0;
      bus.spawn_valid = 1'b0;
      bus.spawn_lane  = 3'd0;
      bus.hit_valid   = 1'b0;
      bus.hit_lane    = 3'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_act[i] = 0; m_lane[i] = 0; m_pos[i] = 0;
      end

      // Reset state
      repeat (5) @(negedge clk50);
      check("rst we", bus.vga_ram_we, 0);
      check("rst busy", bus.busy, 0);
      check("rst spawn_ready", bus.spawn_ready, 0);
      check("rst miss", bus.miss, 0);
      check("rst addr", bus.vga_ram_addr, 0);

      // Clear sweep
      rst_n = 1'b1;
      repeat (10) @(negedge clk50);
      check("clear busy", bus.busy, 1);
      check("clear ready", bus.spawn_ready, 0);
      wait_idle("clear", 6000);
      n = act_q.size() - rd_ptr;
      check("clear wr_count", n, 4096);
      mism = 0;
      for (int i = 0; i < n && i < 4096; i++)
         if (act_q[rd_ptr + i] !== {12'(i), 1'b0}) mism++;
      check("clear wr_data", mism, 0);
      rd_ptr = act_q.size();
      check("idle spawn_ready", bus.spawn_ready, 1);
      check("idle hit_ready", bus.hit_ready, 1);

      // First spawn and first tick; hit outside the window fails
      drive_spawn(3);
      drive_tick();
      drive_hit(3);

      // Two lane-2 notes 20 rows apart, with random spawns/hits sprinkled in
      repeat (9) drive_tick();
      drive_spawn(2);
      repeat (10) drive_tick();
      drive_spawn(2);
      for (int k = 0; k < 210; k++) begin
         if (k == 50 || k == 120) drive_spawn(int'($urandom_range(0, 7)));
         if (k == 80 || k == 160) drive_hit(int'($urandom_range(0, 6)));
         drive_tick();
      end

      // Note at 440 beats the one at 420
      base = rd_ptr;
      drive_hit(2);
      check("hit first erase", (act_q.size() > base) ? act_q[base] : 13'h1fff,
            {9'd440, 3'd2, 1'b0});
      drive_hit(5);

      // Remaining lane-2 note walks to the bottom and is retired
      repeat (23) drive_tick();
      check("last miss lane", (act_miss_q.size() > 0) ? act_miss_q[act_miss_q.size() - 1] : -1, 2);

      // Fill all slots, then one more spawn is dropped
      while (m_count() < NUM_SLOTS) drive_spawn(int'($urandom_range(0, 6)));
      drive_spawn(int'($urandom_range(0, 6)));

      // Two ticks during one TICK: one becomes pending, the other is lost
      @(negedge clk50);
      bus.frame_tick = 1'b1;
      @(negedge clk50);
      bus.frame_tick = 1'b0;
      m_tick();
      n = 0;
      while (bus.busy !== 1'b1 && n < 50) begin
         @(negedge clk50);
         n++;
      end
      check("ovr busy", bus.busy, 1);
      repeat (20) @(negedge clk50);
      bus.frame_tick = 1'b1;
      @(negedge clk50);
      bus.frame_tick = 1'b0;
      m_tick();
      repeat (20) @(negedge clk50);
      bus.frame_tick = 1'b1;
      @(negedge clk50);
      bus.frame_tick = 1'b0;
      exp_ovr++;
      wait_idle("overrun", 6000);
      check_writes("overrun");
      check_pulses("overrun");

      // Miss lanes in order
      mism = 0;
      for (int i = 0; i < act_miss_q.size() && i < exp_miss_q.size(); i++)
         if (act_miss_q[i] != exp_miss_q[i]) mism++;
      check("miss lanes", mism, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
